// File: rtl/ex_alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
//   Shared definitions for the EX ALU arbiter slice: ALUop encodings, the
//   arbiter FSM state type with its state constants, and the helper that
//   tells a real ALU operation apart from a non-ALU op.
//   Ports: none (package).
//   Configuration macro used elsewhere in this slice: ALU_ARB_FIXED_PRIO_EN.
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  localparam logic [4:0] OP_ADD  = 5'b01101;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_SUB  = 5'b01110;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_SRL  = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00100;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Bit 4 of ALUop marks branch/jump/memory/other ops that the ALU cannot serve.
  function automatic logic is_alu_op(input logic op_msb);
    return ~op_msb;
  endfunction

endpackage

// File: rtl/ex_alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// ex_alu_arbiter_if
//   Bundles the requester, shared-ALU and response signals of the EX ALU
//   arbiter. Signal suffixes are named from the arbiter's point of view.
//   Parameters: NREQ requesters, IDW width of the response id.
//   Modports:
//     slave  - the arbiter (accepts requests, drives ALU and responses)
//     master - requesters / ALU / response consumer side
//   Signals:
//     req_valid_i, req_op_i, req_a_i, req_b_i, req_ready_o  request channel
//     alu_op_o, alu_a_o, alu_b_o, alu_result_i               shared ALU
//     rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_data_o, rsp_err_o  response
// ---------------------------------------------------------------------------
interface ex_alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [NREQ*5-1:0]  req_op_i;
  logic [NREQ*32-1:0] req_a_i;
  logic [NREQ*32-1:0] req_b_i;

  logic [4:0]         alu_op_o;
  logic [31:0]        alu_a_o;
  logic [31:0]        alu_b_o;
  logic [31:0]        alu_result_i;

  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [IDW-1:0]     rsp_id_o;
  logic [31:0]        rsp_data_o;
  logic               rsp_err_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, alu_result_i, rsp_ready_i,
    output req_ready_o, alu_op_o, alu_a_o, alu_b_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, alu_result_i, rsp_ready_i,
    input  req_ready_o, alu_op_o, alu_a_o, alu_b_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
  );

endinterface

// File: rtl/ex_alu_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// alu_rr_picker
//   Combinational request picker for the EX ALU arbiter.
//   Default build: round-robin, scanning upward from ptr_i with wrap-around;
//   the first valid requester wins.
//   With ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
//   and the ptr_i port does not exist.
//   Ports:
//     valid_i  in  NREQ  request valids
//     ptr_i    in  IDW   round-robin start index (round-robin build only)
//     grant_o  out NREQ  one-hot winner (zero if no valid)
//     idx_o    out IDW   index of the winner
//     any_o    out 1     some requester is valid
// ---------------------------------------------------------------------------
module alu_rr_picker #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]  ptr_i,
`endif
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Lowest index first; the found flag stops later candidates overriding.
  always_comb begin
    logic found;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = IDW'(k);
      end
    end
    any_o = found;
  end

`else

  // Candidate k is (ptr + k) mod NREQ, so the scan wraps past NREQ-1 to 0.
  always_comb begin
    logic found;
    int   cand;
    found   = 1'b0;
    cand    = 0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDW'(cand);
      end
    end
    any_o = found;
  end

`endif

endmodule

// File: rtl/ex_alu_arbiter.sv
// ---------------------------------------------------------------------------
// ex_alu_arbiter
//   Shares one combinational 32-bit EX ALU among NREQ requesters. One
//   operation is in flight at a time: the winner's op/operands are registered
//   onto the ALU for ALU_LAT cycles, then the result is captured into a
//   response register held under a valid/ready handshake. Non-ALU ops
//   (ALUop[4]=1) skip the ALU and respond next cycle with rsp_err_o=1.
//   Parameters: NREQ (>=2), ALU_LAT (>=1), IDW = $clog2(NREQ).
//   Ports:
//     clk     in   clock, rising edge
//     rst_n   in   asynchronous reset, active-low
//     bus     ex_alu_arbiter_if.slave (request, ALU and response channels)
//     busy_o  out  arbiter is not idle
//   Configuration: ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest
//   index wins) and removes the round-robin pointer; default is round-robin.
// ---------------------------------------------------------------------------
module ex_alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 1,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_alu_arbiter_if.slave      bus,
  output logic                 busy_o
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      alu_op_q, alu_op_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  ptr_q, ptr_d;
`endif

  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            accept;
  logic [4:0]      sel_op;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  alu_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .valid_i (bus.req_valid_i),
`ifndef ALU_ARB_FIXED_PRIO_EN
    .ptr_i   (ptr_q),
`endif
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Grants are only offered while idle, so at most one op is ever in flight.
  assign accept          = (state_q == ST_IDLE) && pick_any;
  assign bus.req_ready_o = (state_q == ST_IDLE) ? pick_grant : '0;

  // One-hot mux of the winner's op and operands.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_op = bus.req_op_i[i*5 +: 5];
        sel_a  = bus.req_a_i[i*32 +: 32];
        sel_b  = bus.req_b_i[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_op_d = sel_op;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          rsp_id_d = pick_idx;
          cnt_d    = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
`endif
          if (is_alu_op(sel_op[4])) begin
            state_d = ST_BUSY;
          end else begin
            // Non-ALU op answers immediately with an error and no data.
            state_d    = ST_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        end
      end

      ST_BUSY: begin
        // The ALU has seen stable operands for ALU_LAT cycles on the last one.
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_RESP;
          rsp_data_d = bus.alu_result_i;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.alu_op_o    = alu_op_q;
  assign bus.alu_a_o     = alu_a_q;
  assign bus.alu_b_o     = alu_b_q;
  assign bus.rsp_valid_o = (state_q == ST_RESP);
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ex_alu_arbiter
//   Directed bench for ex_alu_arbiter. Two instances share clock and reset:
//   dut1 with ALU_LAT=1 (main scenarios) and dut3 with ALU_LAT=3.
//   A small combinational ALU closes the loop on alu_*_o -> alu_result_i.
// ---------------------------------------------------------------------------
module tb_ex_alu_arbiter;

  import alu_arb_pkg::*;

  logic clk;
  logic rst_n;
  logic busy1;
  logic busy3;

  int testsRun;
  int testsFailed;

  ex_alu_arbiter_if #(.NREQ(2), .IDW(1)) bus1 ();
  ex_alu_arbiter_if #(.NREQ(2), .IDW(1)) bus3 ();

  ex_alu_arbiter #(.NREQ(2), .ALU_LAT(1), .IDW(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus1),
    .busy_o (busy1)
  );

  ex_alu_arbiter #(.NREQ(2), .ALU_LAT(3), .IDW(1)) u_dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus3),
    .busy_o (busy3)
  );

  // Stand-in for the shared EX ALU datapath.
  function automatic logic [31:0] aluCalc(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD, OP_ADDI: return a + b;
      OP_SUB:          return a - b;
      OP_SLL:          return a << b[4:0];
      OP_SRL:          return a >> b[4:0];
      OP_XOR:          return a ^ b;
      OP_OR:           return a | b;
      OP_AND:          return a & b;
      default:         return 32'h0;
    endcase
  endfunction

  assign bus1.alu_result_i = aluCalc(bus1.alu_op_o, bus1.alu_a_o, bus1.alu_b_o);
  assign bus3.alu_result_i = aluCalc(bus3.alu_op_o, bus3.alu_a_o, bus3.alu_b_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic rdy);
    bus1.req_valid_i = valid;
    bus1.req_op_i    = {op1, op0};
    bus1.req_a_i     = {a1, a0};
    bus1.req_b_i     = {b1, b0};
    bus1.rsp_ready_i = rdy;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    bus3.req_valid_i = 2'b00;
    bus3.req_op_i    = '0;
    bus3.req_a_i     = '0;
    bus3.req_b_i     = '0;
    bus3.rsp_ready_i = 1'b0;

    // ---- reset state ----
    nextCycle();
    nextCycle();
    checkOutput("rst_rsp_valid", 32'(bus1.rsp_valid_o), 32'd0);
    checkOutput("rst_busy",      32'(busy1),            32'd0);
    checkOutput("rst_req_ready", 32'(bus1.req_ready_o), 32'd0);
    checkOutput("rst_alu_a",     bus1.alu_a_o,          32'd0);
    checkOutput("rst_rsp_data",  bus1.rsp_data_o,       32'd0);
    checkOutput("rst3_busy",     32'(busy3),            32'd0);
    rst_n = 1'b1;
    nextCycle();

    // ---- single ADD from requester 0 ----
    applyStimulus(2'b01, OP_ADD, 32'd5, 32'd7, 5'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("add_grant", 32'(bus1.req_ready_o), 32'h1);
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("add_busy",      32'(busy1),            32'd1);
    checkOutput("add_alu_op",    32'(bus1.alu_op_o),    32'(OP_ADD));
    checkOutput("add_alu_a",     bus1.alu_a_o,          32'd5);
    checkOutput("add_alu_b",     bus1.alu_b_o,          32'd7);
    checkOutput("add_early_vld", 32'(bus1.rsp_valid_o), 32'd0);
    nextCycle();
    checkOutput("add_rsp_valid", 32'(bus1.rsp_valid_o), 32'd1);
    checkOutput("add_rsp_data",  bus1.rsp_data_o,       32'd12);
    checkOutput("add_rsp_id",    32'(bus1.rsp_id_o),    32'd0);
    checkOutput("add_rsp_err",   32'(bus1.rsp_err_o),   32'd0);
    nextCycle();
    checkOutput("add_bubble_vld",  32'(bus1.rsp_valid_o), 32'd0);
    checkOutput("add_bubble_busy", 32'(busy1),            32'd0);
    checkOutput("add_alu_a_hold",  bus1.alu_a_o,          32'd5);

    // ---- non-ALU op (LW) from requester 1 ----
    applyStimulus(2'b10, 5'd0, 32'd0, 32'd0, 5'b10100, 32'h100, 32'h4, 1'b1);
    checkOutput("lw_grant", 32'(bus1.req_ready_o), 32'h2);
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("lw_rsp_valid", 32'(bus1.rsp_valid_o), 32'd1);
    checkOutput("lw_rsp_err",   32'(bus1.rsp_err_o),   32'd1);
    checkOutput("lw_rsp_data",  bus1.rsp_data_o,       32'd0);
    checkOutput("lw_rsp_id",    32'(bus1.rsp_id_o),    32'd1);
    nextCycle();
    checkOutput("lw_done", 32'(bus1.rsp_valid_o), 32'd0);

    // ---- round-robin: both valid, four SUBs (100-1=99, 50-20=30) ----
    applyStimulus(2'b11, OP_SUB, 32'd100, 32'd1, OP_SUB, 32'd50, 32'd20, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr%0d_grant", i), 32'(bus1.req_ready_o), (i % 2 == 0) ? 32'h1 : 32'h2);
      nextCycle();
      if (i == 3) applyStimulus(2'b00, OP_SUB, 32'd100, 32'd1, OP_SUB, 32'd50, 32'd20, 1'b1);
      checkOutput($sformatf("rr%0d_busy_ready", i), 32'(bus1.req_ready_o), 32'd0);
      nextCycle();
      checkOutput($sformatf("rr%0d_valid", i), 32'(bus1.rsp_valid_o), 32'd1);
      checkOutput($sformatf("rr%0d_id", i),    32'(bus1.rsp_id_o),    (i % 2 == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("rr%0d_data", i),  bus1.rsp_data_o,       (i % 2 == 0) ? 32'd99 : 32'd30);
      nextCycle();
    end
    checkOutput("rr_idle", 32'(busy1), 32'd0);

    // ---- backpressure: SLL 1<<31 held while rsp_ready_i=0, req1 waits ----
    applyStimulus(2'b01, OP_SLL, 32'd1, 32'd31, OP_OR, 32'h0F0, 32'hF00, 1'b0);
    checkOutput("bp_grant", 32'(bus1.req_ready_o), 32'h1);
    nextCycle();
    applyStimulus(2'b10, OP_SLL, 32'd1, 32'd31, OP_OR, 32'h0F0, 32'hF00, 1'b0);
    checkOutput("bp_busy_ready", 32'(bus1.req_ready_o), 32'd0);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d_valid", i), 32'(bus1.rsp_valid_o), 32'd1);
      checkOutput($sformatf("bp%0d_data", i),  bus1.rsp_data_o,       32'h8000_0000);
      checkOutput($sformatf("bp%0d_id", i),    32'(bus1.rsp_id_o),    32'd0);
      checkOutput($sformatf("bp%0d_ready", i), 32'(bus1.req_ready_o), 32'd0);
      nextCycle();
    end
    applyStimulus(2'b10, OP_SLL, 32'd1, 32'd31, OP_OR, 32'h0F0, 32'hF00, 1'b1);
    checkOutput("bp_release_data", bus1.rsp_data_o, 32'h8000_0000);
    nextCycle();
    checkOutput("bp_bubble_valid", 32'(bus1.rsp_valid_o), 32'd0);
    checkOutput("bp_next_grant",   32'(bus1.req_ready_o), 32'h2);
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    nextCycle();
    checkOutput("or_valid", 32'(bus1.rsp_valid_o), 32'd1);
    checkOutput("or_data",  bus1.rsp_data_o,       32'h0000_0FF0);
    checkOutput("or_id",    32'(bus1.rsp_id_o),    32'd1);
    nextCycle();

    // ---- ALU_LAT=3 instance: XOR held 3 cycles, response at t+4 ----
    bus3.req_valid_i = 2'b01;
    bus3.req_op_i    = {5'd0, OP_XOR};
    bus3.req_a_i     = {32'd0, 32'hF0F0_F0F0};
    bus3.req_b_i     = {32'd0, 32'hFFFF_0000};
    bus3.rsp_ready_i = 1'b1;
    #1;
    checkOutput("lat3_grant", 32'(bus3.req_ready_o), 32'h1);
    nextCycle();
    bus3.req_valid_i = 2'b00;
    bus3.req_a_i     = '0;
    bus3.req_b_i     = '0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("lat3_%0d_op", i),    32'(bus3.alu_op_o),    32'(OP_XOR));
      checkOutput($sformatf("lat3_%0d_a", i),     bus3.alu_a_o,          32'hF0F0_F0F0);
      checkOutput($sformatf("lat3_%0d_b", i),     bus3.alu_b_o,          32'hFFFF_0000);
      checkOutput($sformatf("lat3_%0d_valid", i), 32'(bus3.rsp_valid_o), 32'd0);
      checkOutput($sformatf("lat3_%0d_busy", i),  32'(busy3),            32'd1);
      nextCycle();
    end
    checkOutput("lat3_rsp_valid", 32'(bus3.rsp_valid_o), 32'd1);
    checkOutput("lat3_rsp_data",  bus3.rsp_data_o,       32'h0F0F_F0F0);
    checkOutput("lat3_rsp_err",   32'(bus3.rsp_err_o),   32'd0);
    nextCycle();
    checkOutput("lat3_done",   32'(bus3.rsp_valid_o), 32'd0);
    checkOutput("lat3_a_hold", bus3.alu_a_o,          32'hF0F0_F0F0);

    // ---- reset in the middle of an operation ----
    applyStimulus(2'b01, OP_ADD, 32'h1234, 32'd1, 5'd0, 32'd0, 32'd0, 1'b1);
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("mid_busy_pre", 32'(busy1),   32'd1);
    checkOutput("mid_alu_a",    bus1.alu_a_o, 32'h1234);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(bus1.rsp_valid_o), 32'd0);
    checkOutput("mid_rst_busy",  32'(busy1),            32'd0);
    checkOutput("mid_rst_alu_a", bus1.alu_a_o,          32'd0);
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput($sformatf("post_rst%0d_valid", i), 32'(bus1.rsp_valid_o), 32'd0);
      checkOutput($sformatf("post_rst%0d_data", i),  bus1.rsp_data_o,       32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
